ex_stage_sequencer: RTL and testbench

Control sequencer for the EX stage. It accepts one decoded instruction per cycle from ID and evaluates its ARM condition code against an architectural NZCV flag register. It commits the ALU flags, steers the ALU carry-in and address mux, and hands results to MEM over a valid/ready handshake. On a taken branch it flushes the younger instructions.

---
 rtl/ex_stage_sequencer_pkg.sv | 57 +++++
 rtl/ex_stage_sequencer_cond_eval.sv | 40 ++++
 rtl/ex_stage_sequencer.sv | 114 +++++++++++
 tb/tb_ex_stage_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_sequencer_pkg.sv
// Shared encodings for the EX-stage sequencer: ARM condition codes, ALU opcodes,
// sequencer states and NZCV flag bit positions.
package ex_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Compares (TST..CMN) always set flags and never write a destination register.
    localparam logic [3:0] OP_CMP_FIRST = OP_TST;
    localparam logic [3:0] OP_CMP_LAST  = OP_CMN;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ex_state_e;

    function automatic logic is_compare(input logic [3:0] op);
        return (op >= OP_CMP_FIRST) && (op <= OP_CMP_LAST);
    endfunction

endpackage

// File: rtl/ex_stage_sequencer_cond_eval.sv
// Purely combinational ARM condition-code evaluator; also reused by the
// ID-stage branch predictor, so it carries no sequencer state.
module ex_cond_eval
    import ex_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage_sequencer.sv
// EX-stage control: condition check, flag commit, EX/MEM handshake and the
// post-branch squash window.
module ex_stage_sequencer
    import ex_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    output logic       id_ready,
    input  logic [3:0] id_cond,
    input  logic [3:0] id_alu_op,
    input  logic       id_s_bit,
    input  logic       id_is_branch,
    input  logic       id_is_ls,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    output logic       alu_ci,
    output logic       addr_sel,
    output logic [3:0] flags_q,
    output logic       cond_pass,
    output logic       flush,
    output logic       mem_valid,
    input  logic       mem_ready,
    output logic       mem_wb_en,
    output logic       mem_is_ls
);

    ex_state_e  state;
    ex_state_e  state_next;
    logic [2:0] squash_cnt;
    logic       eval_pass;
    logic       accept;
    logic       run_pass;
    logic       taken_branch;
    logic       flags_we;
    logic       wb_en_next;

    ex_cond_eval u_cond_eval (
        .cond  (id_cond),
        .flags (flags_q),
        .pass  (eval_pass)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (taken_branch) state_next = FLUSH;
            FLUSH:   if (accept && (squash_cnt == 3'd1)) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Inside the squash window every slot reads as a failed condition, so the
    // same bubble path handles both.
    always_comb begin
        id_ready     = !mem_valid || mem_ready;
        accept       = id_valid && id_ready;
        cond_pass    = (state == RUN) && eval_pass;
        run_pass     = accept && cond_pass;
        taken_branch = run_pass && id_is_branch;
        flags_we     = run_pass && (is_compare(id_alu_op) || id_s_bit);
        wb_en_next   = !is_compare(id_alu_op) && !id_is_branch && !id_is_ls;
        alu_ci       = flags_q[FLAG_C];
        addr_sel     = id_is_ls;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            squash_cnt <= 3'd0;
        end else if (taken_branch) begin
            squash_cnt <= 3'(FLUSH_CYCLES);
        end else if ((state == FLUSH) && accept && (squash_cnt != 3'd0)) begin
            squash_cnt <= squash_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush   <= 1'b0;
            flags_q <= 4'b0000;
        end else begin
            flush <= taken_branch;
            if (flags_we) begin
                flags_q <= {alu_n, alu_z, alu_c, alu_v};
            end
        end
    end

    // EX/MEM register only moves when the slot downstream is free.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_wb_en <= 1'b0;
            mem_is_ls <= 1'b0;
        end else if (id_ready) begin
            mem_valid <= run_pass;
            mem_wb_en <= run_pass && wb_en_next;
            mem_is_ls <= run_pass && id_is_ls;
        end
    end

endmodule

// File: tb/tb_ex_stage_sequencer.sv
// Directed self-checking bench for ex_stage_sequencer: flag commit, branch
// squash window, MEM stalls, mid-flush reset and the full condition table.
module tb_ex_stage_sequencer;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic       id_ready;
    logic [3:0] id_cond;
    logic [3:0] id_alu_op;
    logic       id_s_bit;
    logic       id_is_branch;
    logic       id_is_ls;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic       alu_ci;
    logic       addr_sel;
    logic [3:0] flags_q;
    logic       cond_pass;
    logic       flush;
    logic       mem_valid;
    logic       mem_ready;
    logic       mem_wb_en;
    logic       mem_is_ls;

    int n_cmp  = 0;
    int n_fail = 0;

    ex_stage_sequencer #(.FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_cond      (id_cond),
        .id_alu_op    (id_alu_op),
        .id_s_bit     (id_s_bit),
        .id_is_branch (id_is_branch),
        .id_is_ls     (id_is_ls),
        .alu_n        (alu_n),
        .alu_z        (alu_z),
        .alu_c        (alu_c),
        .alu_v        (alu_v),
        .alu_ci       (alu_ci),
        .addr_sel     (addr_sel),
        .flags_q      (flags_q),
        .cond_pass    (cond_pass),
        .flush        (flush),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_wb_en    (mem_wb_en),
        .mem_is_ls    (mem_is_ls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [3:0] c, input logic [3:0] op,
                            input logic s, input logic br, input logic ls,
                            input logic [3:0] nzcv);
        id_valid     = v;
        id_cond      = c;
        id_alu_op    = op;
        id_s_bit     = s;
        id_is_branch = br;
        id_is_ls     = ls;
        {alu_n, alu_z, alu_c, alu_v} = nzcv;
        #1;
    endtask

    // Reference condition table written from the ARM definitions.
    function automatic logic expected_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        drive_id(1'b0, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        tick();
        n_cmp++; if (flags_q !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags got %b want 0000", flags_q); end
        n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_valid got %b want 0", mem_valid); end
        n_cmp++; if (mem_wb_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wb_en got %b want 0", mem_wb_en); end
        n_cmp++; if (mem_is_ls !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_is_ls got %b want 0", mem_is_ls); end
        n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flush got %b want 0", flush); end
        reset = 1'b0;
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_id_ready got %b want 1", id_ready); end
    endtask

    task automatic test_adds_beq();
        drive_id(1'b1, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0, 4'b0100);
        n_cmp++; if (cond_pass !== 1'b1) begin n_fail++; $display("[TB] FAIL adds_cond_pass got %b want 1", cond_pass); end
        tick();
        n_cmp++; if (flags_q !== 4'b0100) begin n_fail++; $display("[TB] FAIL adds_flags got %b want 0100", flags_q); end
        n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL adds_mem_valid got %b want 1", mem_valid); end
        n_cmp++; if (mem_wb_en !== 1'b1) begin n_fail++; $display("[TB] FAIL adds_wb_en got %b want 1", mem_wb_en); end
        n_cmp++; if (alu_ci !== 1'b0) begin n_fail++; $display("[TB] FAIL adds_alu_ci got %b want 0", alu_ci); end
        drive_id(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'b1111);
        n_cmp++; if (cond_pass !== 1'b1) begin n_fail++; $display("[TB] FAIL beq_cond_pass got %b want 1", cond_pass); end
        tick();
        n_cmp++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL beq_flush got %b want 1", flush); end
        n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL beq_mem_valid got %b want 1", mem_valid); end
        n_cmp++; if (mem_wb_en !== 1'b0) begin n_fail++; $display("[TB] FAIL beq_wb_en got %b want 0", mem_wb_en); end
        n_cmp++; if (flags_q !== 4'b0100) begin n_fail++; $display("[TB] FAIL beq_flags got %b want 0100", flags_q); end
        drive_id(1'b1, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0, 4'b1000);
        n_cmp++; if (cond_pass !== 1'b0) begin n_fail++; $display("[TB] FAIL squash1_cond_pass got %b want 0", cond_pass); end
        tick();
        n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL squash1_flush got %b want 0", flush); end
        n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL squash1_mem_valid got %b want 0", mem_valid); end
        n_cmp++; if (flags_q !== 4'b0100) begin n_fail++; $display("[TB] FAIL squash1_flags got %b want 0100", flags_q); end
        tick();
        n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL squash2_mem_valid got %b want 0", mem_valid); end
        n_cmp++; if (flags_q !== 4'b0100) begin n_fail++; $display("[TB] FAIL squash2_flags got %b want 0100", flags_q); end
        drive_id(1'b1, 4'hE, 4'h4, 1'b0, 1'b0, 1'b0, 4'b0000);
        n_cmp++; if (cond_pass !== 1'b1) begin n_fail++; $display("[TB] FAIL back_to_run_cond_pass got %b want 1", cond_pass); end
        tick();
        n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL back_to_run_mem_valid got %b want 1", mem_valid); end
    endtask

    task automatic test_cmp_no_s();
        drive_id(1'b1, 4'hE, 4'hA, 1'b0, 1'b0, 1'b0, 4'b1000);
        tick();
        n_cmp++; if (flags_q !== 4'b1000) begin n_fail++; $display("[TB] FAIL cmp_flags got %b want 1000", flags_q); end
        n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL cmp_mem_valid got %b want 1", mem_valid); end
        n_cmp++; if (mem_wb_en !== 1'b0) begin n_fail++; $display("[TB] FAIL cmp_wb_en got %b want 0", mem_wb_en); end
    endtask

    task automatic test_failed_cond();
        drive_id(1'b1, 4'hE, 4'hA, 1'b0, 1'b0, 1'b0, 4'b0100);
        tick();
        drive_id(1'b1, 4'h1, 4'hD, 1'b1, 1'b0, 1'b0, 4'b0010);
        n_cmp++; if (cond_pass !== 1'b0) begin n_fail++; $display("[TB] FAIL movne_cond_pass got %b want 0", cond_pass); end
        tick();
        n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL movne_mem_valid got %b want 0", mem_valid); end
        n_cmp++; if (flags_q !== 4'b0100) begin n_fail++; $display("[TB] FAIL movne_flags got %b want 0100", flags_q); end
    endtask

    task automatic test_mem_stall();
        drive_id(1'b1, 4'hE, 4'h4, 1'b0, 1'b0, 1'b1, 4'b0000);
        n_cmp++; if (addr_sel !== 1'b1) begin n_fail++; $display("[TB] FAIL ldr_addr_sel got %b want 1", addr_sel); end
        tick();
        n_cmp++; if (mem_is_ls !== 1'b1) begin n_fail++; $display("[TB] FAIL ldr_is_ls got %b want 1", mem_is_ls); end
        mem_ready = 1'b0;
        drive_id(1'b1, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (id_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_id_ready[%0d] got %b want 0", i, id_ready); end
            tick();
            n_cmp++; if ({mem_valid, mem_wb_en, mem_is_ls} !== 3'b101) begin n_fail++; $display("[TB] FAIL stall_hold[%0d] got %b want 101", i, {mem_valid, mem_wb_en, mem_is_ls}); end
            n_cmp++; if (flags_q !== 4'b0100) begin n_fail++; $display("[TB] FAIL stall_flags[%0d] got %b want 0100", i, flags_q); end
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_id_ready got %b want 1", id_ready); end
        tick();
        n_cmp++; if ({mem_valid, mem_wb_en, mem_is_ls} !== 3'b110) begin n_fail++; $display("[TB] FAIL release_result got %b want 110", {mem_valid, mem_wb_en, mem_is_ls}); end
        n_cmp++; if (flags_q !== 4'b0001) begin n_fail++; $display("[TB] FAIL release_flags got %b want 0001", flags_q); end
        n_cmp++; if (alu_ci !== 1'b0) begin n_fail++; $display("[TB] FAIL release_alu_ci got %b want 0", alu_ci); end
    endtask

    task automatic test_flush_stall_rebranch();
        drive_id(1'b1, 4'hE, 4'hD, 1'b0, 1'b1, 1'b0, 4'b0000);
        tick();
        n_cmp++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL b_flush got %b want 1", flush); end
        mem_ready = 1'b0;
        drive_id(1'b1, 4'hE, 4'hD, 1'b0, 1'b1, 1'b0, 4'b0000);
        n_cmp++; if (id_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fstall_id_ready got %b want 0", id_ready); end
        n_cmp++; if (cond_pass !== 1'b0) begin n_fail++; $display("[TB] FAIL fstall_cond_pass got %b want 0", cond_pass); end
        tick();
        n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL fstall_flush got %b want 0", flush); end
        tick();
        n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL fstall_mem_valid got %b want 1", mem_valid); end
        mem_ready = 1'b1;
        tick();
        n_cmp++; if ({flush, mem_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL rebranch1 got %b want 00", {flush, mem_valid}); end
        tick();
        n_cmp++; if ({flush, mem_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL rebranch2 got %b want 00", {flush, mem_valid}); end
        drive_id(1'b1, 4'hE, 4'h4, 1'b0, 1'b0, 1'b0, 4'b0000);
        n_cmp++; if (cond_pass !== 1'b1) begin n_fail++; $display("[TB] FAIL after_flush_cond_pass got %b want 1", cond_pass); end
        tick();
        n_cmp++; if ({mem_valid, mem_wb_en, flush} !== 3'b110) begin n_fail++; $display("[TB] FAIL after_flush_result got %b want 110", {mem_valid, mem_wb_en, flush}); end
    endtask

    task automatic test_reset_mid_flush();
        drive_id(1'b1, 4'hE, 4'hD, 1'b0, 1'b1, 1'b0, 4'b0000);
        tick();
        drive_id(1'b1, 4'hE, 4'h4, 1'b0, 1'b0, 1'b0, 4'b0000);
        tick();
        reset = 1'b1;
        drive_id(1'b1, 4'hE, 4'h4, 1'b1, 1'b0, 1'b1, 4'b1111);
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (flags_q !== 4'b0000) begin n_fail++; $display("[TB] FAIL mrst_flags got %b want 0000", flags_q); end
        n_cmp++; if ({mem_valid, mem_wb_en, mem_is_ls, flush} !== 4'b0000) begin n_fail++; $display("[TB] FAIL mrst_outputs got %b want 0000", {mem_valid, mem_wb_en, mem_is_ls, flush}); end
        drive_id(1'b1, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0, 4'b0010);
        n_cmp++; if (cond_pass !== 1'b1) begin n_fail++; $display("[TB] FAIL mrst_cond_pass got %b want 1", cond_pass); end
        tick();
        n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mrst_mem_valid got %b want 1", mem_valid); end
        n_cmp++; if (flags_q !== 4'b0010) begin n_fail++; $display("[TB] FAIL mrst_next_flags got %b want 0010", flags_q); end
        n_cmp++; if (alu_ci !== 1'b1) begin n_fail++; $display("[TB] FAIL mrst_alu_ci got %b want 1", alu_ci); end
    endtask

    task automatic test_cond_sweep();
        logic [3:0] f;
        logic [3:0] c;
        logic       exp_pass;
        for (int fi = 0; fi < 16; fi++) begin
            f = 4'(fi);
            drive_id(1'b1, 4'hE, 4'hA, 1'b0, 1'b0, 1'b0, f);
            tick();
            id_valid = 1'b0;
            n_cmp++; if (flags_q !== f) begin n_fail++; $display("[TB] FAIL sweep_flags got %b want %b", flags_q, f); end
            for (int ci = 0; ci < 16; ci++) begin
                c = 4'(ci);
                id_cond = c;
                #1;
                exp_pass = expected_pass(c, f);
                n_cmp++; if (cond_pass !== exp_pass) begin n_fail++; $display("[TB] FAIL sweep cond=%b flags=%b got %b want %b", c, f, cond_pass, exp_pass); end
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_adds_beq();
        test_cmp_no_s();
        test_failed_cond();
        test_mem_stall();
        test_flush_stall_rebranch();
        test_reset_mid_flush();
        test_cond_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
